// File: rtl/sram_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sram_access_ctrl                                                  |
// | Brief  : byte/half/word request controller for a 2048x32 byte-laned SRAM;  |
// |          optional misalignment check under SRAM_ACCESS_ALIGN_CHECK_EN.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module sram_access_ctrl #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  int_clock,
  input  logic                  int_reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_read,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_write_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_error,
  output logic                  sram_read,
  output logic                  sram_write,
  output logic [3:0]            sram_byte_enables,
  output logic [ADDR_WIDTH-3:0] sram_address,
  output logic [31:0]           sram_write_data,
  input  logic [31:0]           sram_read_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_accept;
  logic        w_misalign;
  logic        w_strobe;
  logic        w_is_byte;
  logic        w_is_half;
  logic [1:0]  r_offset;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_misalign;
  logic [31:0] r_resp_data;
  logic        r_resp_error;
  logic [7:0]  w_rd_byte;
  logic [15:0] w_rd_half;
  logic [31:0] w_aligned;

  assign w_is_byte = (req_size == 2'd0);
  assign w_is_half = (req_size == 2'd1);

  assign req_ready = !int_reset && ((r_state == S_IDLE) || ((r_state == S_RESP) && resp_ready));
  assign w_accept  = req_valid && req_ready;

`ifdef SRAM_ACCESS_ALIGN_CHECK_EN
  // Misaligned requests are still accepted, they just never touch the SRAM
  assign w_misalign = (w_is_half && req_address[0]) ||
                      (req_size[1] && (req_address[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_strobe     = w_accept && !w_misalign;
  assign sram_read    = w_strobe && req_read;
  assign sram_write   = w_strobe && !req_read;
  assign sram_address = req_address[ADDR_WIDTH-1:2];

  always_comb begin
    sram_byte_enables = 4'b0000;
    sram_write_data   = 32'd0;
    if (w_strobe) begin
      if (w_is_byte) begin
        sram_byte_enables = 4'b0001 << req_address[1:0];
        sram_write_data   = {4{req_write_data[7:0]}};
      end else if (w_is_half) begin
        sram_byte_enables = req_address[1] ? 4'b1100 : 4'b0011;
        sram_write_data   = {2{req_write_data[15:0]}};
      end else begin
        sram_byte_enables = 4'b1111;
        sram_write_data   = req_write_data;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept && req_read) w_state_next = S_RD_WAIT;
      S_RD_WAIT: w_state_next = S_RESP;
      S_RESP:    if (resp_ready) w_state_next = (w_accept && req_read) ? S_RD_WAIT : S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Lane select uses the offset captured at accept; half ignores addr[0]
  assign w_rd_byte = sram_read_data[{r_offset, 3'b000} +: 8];
  assign w_rd_half = sram_read_data[{r_offset[1], 4'b0000} +: 16];

  always_comb begin
    w_aligned = sram_read_data;
    if (r_size == 2'd0)
      w_aligned = {{24{r_signed & w_rd_byte[7]}}, w_rd_byte};
    else if (r_size == 2'd1)
      w_aligned = {{16{r_signed & w_rd_half[15]}}, w_rd_half};
  end

  always_ff @(posedge int_clock or posedge int_reset) begin
    if (int_reset) begin
      r_state      <= S_IDLE;
      r_offset     <= 2'd0;
      r_size       <= 2'd0;
      r_signed     <= 1'b0;
      r_misalign   <= 1'b0;
      r_resp_data  <= 32'd0;
      r_resp_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept && req_read) begin
        r_offset   <= req_address[1:0];
        r_size     <= req_size;
        r_signed   <= req_signed;
        r_misalign <= w_misalign;
      end
      if (r_state == S_RD_WAIT) begin
        r_resp_data  <= r_misalign ? 32'd0 : w_aligned;
        r_resp_error <= r_misalign;
      end
    end
  end

  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_resp_data;
  assign resp_error = r_resp_error;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sram_access_ctrl                                               |
// | Brief  : directed + random bench for sram_access_ctrl with byte-level model|
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sram_access_ctrl;

  logic        int_clock;
  logic        int_reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_read;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [12:0] req_address;
  logic [31:0] req_write_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        sram_read;
  logic        sram_write;
  logic [3:0]  sram_byte_enables;
  logic [10:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;

  logic [31:0] sram_mem [0:2047];
  logic [7:0]  ref_mem  [0:8191];
  logic        init_we;
  logic [10:0] init_idx;
  logic [31:0] init_val;
  int          vectors;
  int          miscompares;

  sram_access_ctrl #(.ADDR_WIDTH(13)) dut (
    .int_clock         (int_clock),
    .int_reset         (int_reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_read          (req_read),
    .req_size          (req_size),
    .req_signed        (req_signed),
    .req_address       (req_address),
    .req_write_data    (req_write_data),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_data         (resp_data),
    .resp_error        (resp_error),
    .sram_read         (sram_read),
    .sram_write        (sram_write),
    .sram_byte_enables (sram_byte_enables),
    .sram_address      (sram_address),
    .sram_write_data   (sram_write_data),
    .sram_read_data    (sram_read_data)
  );

  initial int_clock = 1'b0;
  always #5 int_clock = ~int_clock;

  // SRAM: byte-lane writes, read data registered one cycle after the strobe
  always @(posedge int_clock) begin
    if (init_we) begin
      sram_mem[init_idx] <= init_val;
    end else if (sram_write) begin
      for (int k = 0; k < 4; k++)
        if (sram_byte_enables[k]) sram_mem[sram_address][8*k +: 8] <= sram_write_data[8*k +: 8];
    end
    if (sram_read) sram_read_data <= sram_mem[sram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [12:0] a);
    logic m;
    m = (int'(a) % nbytes(sz)) != 0;
`ifndef SRAM_ACCESS_ALIGN_CHECK_EN
    m = 1'b0;
`endif
    return m;
  endfunction

  function automatic int base_of(input logic [1:0] sz, input logic [12:0] a);
    return int'(a) - (int'(a) % nbytes(sz));
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] sz, input logic sg, input logic [12:0] a);
    logic [31:0] v;
    int nb;
    int b;
    nb = nbytes(sz);
    b  = base_of(sz, a);
    v  = 32'd0;
    if (misaligned(sz, a)) return 32'd0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[b + k];
    if (sg && nb < 4 && v[8*nb-1])
      for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic issue(input logic rd, input logic [1:0] sz, input logic sg,
                       input logic [12:0] a, input logic [31:0] wd, input int hold);
    int          nb;
    int          b;
    logic        mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    nb  = nbytes(sz);
    b   = base_of(sz, a);
    mis = misaligned(sz, a);
    exp_be = mis ? 4'b0000 : 4'(((1 << nb) - 1) << (b % 4));
    exp_wd = 32'd0;
    if (!mis)
      for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = wd[8*(k % nb) +: 8];
    exp_rd = exp_read(sz, sg, a);

    @(negedge int_clock);
    req_valid = 1'b1; req_read = rd; req_size = sz; req_signed = sg;
    req_address = a; req_write_data = wd;
    #1;
    chk("req_ready", 32'(req_ready), 32'd1);
    chk("sram_read", 32'(sram_read), 32'(rd && !mis));
    chk("sram_write", 32'(sram_write), 32'(!rd && !mis));
    chk("byte_en", 32'(sram_byte_enables), 32'(exp_be));
    if (!mis) chk("sram_addr", 32'(sram_address), 32'(a[12:2]));
    if (!rd) chk("wr_data", sram_write_data, exp_wd);

    @(negedge int_clock);
    req_valid = 1'b0;
    if (!rd) begin
      if (!mis)
        for (int k = 0; k < nb; k++) ref_mem[b + k] = wd[8*k +: 8];
      #1 chk("wr_no_resp", 32'(resp_valid), 32'd0);
    end else begin
      #1 chk("resp_early", 32'(resp_valid), 32'd0);
      chk("ready_wait", 32'(req_ready), 32'd0);
      @(negedge int_clock);
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_data", resp_data, exp_rd);
      chk("resp_error", 32'(resp_error), 32'(mis));
      for (int h = 0; h < hold; h++) begin
        @(negedge int_clock);
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_ready", 32'(req_ready), 32'd0);
        chk("hold_data", resp_data, exp_rd);
      end
      resp_ready = 1'b1;
      #1 chk("resp_ready_pass", 32'(req_ready), 32'd1);
      @(negedge int_clock);
      resp_ready = 1'b0;
      #1 chk("resp_drop", 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    vectors = 0; miscompares = 0;
    int_reset = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_address = 13'd0; req_write_data = 32'd0; resp_ready = 1'b0;
    init_we = 1'b0; init_idx = 11'd0; init_val = 32'd0;

    // Preload the low 64 words of SRAM and mirror them into the byte model
    for (int i = 0; i < 64; i++) begin
      @(negedge int_clock);
      init_we = 1'b1; init_idx = 11'(i); init_val = $urandom();
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = init_val[8*k +: 8];
    end
    @(negedge int_clock);
    init_we = 1'b0; req_valid = 1'b1; req_read = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_sram_read", 32'(sram_read), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    @(negedge int_clock);
    req_valid = 1'b0; int_reset = 1'b0;
    #1 chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Directed: word write, signed byte read, half write + read back
    issue(1'b0, 2'd2, 1'b0, 13'h010, 32'hDEADBEEF, 0);
    chk("model_word4", {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]}, 32'hDEADBEEF);
    issue(1'b1, 2'd0, 1'b1, 13'h013, 32'd0, 0);
    chk("model_sbyte", exp_read(2'd0, 1'b1, 13'h013), 32'hFFFFFFDE);
    issue(1'b0, 2'd1, 1'b0, 13'h022, 32'h00001234, 0);
    issue(1'b1, 2'd1, 1'b0, 13'h022, 32'd0, 0);

    // Held response, then a queued read accepted in the same cycle it is released
    @(negedge int_clock);
    req_valid = 1'b1; req_read = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_address = 13'h010;
    #1 chk("b2b_first_rd", 32'(sram_read), 32'd1);
    @(negedge int_clock);
    req_size = 2'd0; req_address = 13'h022;
    #1 chk("b2b_wait_ready", 32'(req_ready), 32'd0);
    chk("b2b_wait_nostrobe", 32'(sram_read), 32'd0);
    @(negedge int_clock);
    chk("b2b_resp1", resp_data, 32'hDEADBEEF);
    for (int h = 0; h < 5; h++) begin
      @(negedge int_clock);
      chk("b2b_hold_ready", 32'(req_ready), 32'd0);
      chk("b2b_hold_data", resp_data, 32'hDEADBEEF);
    end
    resp_ready = 1'b1;
    #1 chk("b2b_accept", 32'(sram_read), 32'd1);
    chk("b2b_addr", 32'(sram_address), 32'h8);
    @(negedge int_clock);
    resp_ready = 1'b0; req_valid = 1'b0;
    #1 chk("b2b_rdwait", 32'(resp_valid), 32'd0);
    e = exp_read(2'd0, 1'b0, 13'h022);
    @(negedge int_clock);
    chk("b2b_resp2_valid", 32'(resp_valid), 32'd1);
    chk("b2b_resp2", resp_data, e);
    resp_ready = 1'b1;
    @(negedge int_clock);
    resp_ready = 1'b0;

    // Reset while a read is in flight
    req_valid = 1'b1; req_read = 1'b1; req_size = 2'd2; req_address = 13'h010;
    #1 chk("mid_rst_rd", 32'(sram_read), 32'd1);
    @(negedge int_clock);
    int_reset = 1'b1;
    #1 chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_strobe", 32'(sram_read), 32'd0);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    @(negedge int_clock);
    @(negedge int_clock);
    int_reset = 1'b0; req_valid = 1'b0;
    #1 chk("mid_rst_ready_after", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge int_clock);
      chk("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    end

    // Misaligned word read: error response with checking, aligned-down read without
    issue(1'b1, 2'd2, 1'b0, 13'h002, 32'd0, 0);

    for (int n = 0; n < 80; n++)
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            13'($urandom_range(0, 255)), $urandom(), int'($urandom_range(0, 2)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
